// File: rtl/microcode_sequencer.sv
// Microcode sequencer: steps through microsteps, gates the external decoder's control word, latches IR/flags.
// Optional step-overflow watchdog enabled by defining MICROCODE_SEQUENCER_WATCHDOG_EN.
module microcode_sequencer #(
   parameter int unsigned INSTRUCTION_WIDTH  = 16,
   parameter int unsigned INSTRUCTION_STEPS  = 32,
   parameter int unsigned CONTROL_WORD_WIDTH = 32,
   parameter int unsigned FLAG_WIDTH         = 3,
   parameter int unsigned COUNT_WIDTH        = 16,
   parameter int unsigned ADV_BIT            = 0,
   parameter int unsigned HLT_BIT            = 1,
   parameter int unsigned II_BIT             = 2,
   parameter int unsigned EL_BIT             = 3,
   localparam int unsigned STEP_WIDTH = (INSTRUCTION_STEPS > 1) ? $clog2(INSTRUCTION_STEPS) : 1
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_run,
   input  logic                          i_single,
   input  logic                          i_step_pulse,
   input  logic                          i_resume,
   input  logic [INSTRUCTION_WIDTH-1:0]  i_bus,
   input  logic [FLAG_WIDTH-1:0]         i_alu_flags,
   input  logic [CONTROL_WORD_WIDTH-1:0] i_decoded_word,
   output logic [INSTRUCTION_WIDTH-1:0]  o_instruction,
   output logic [STEP_WIDTH-1:0]         o_step,
   output logic [FLAG_WIDTH-1:0]         o_flags,
   output logic [CONTROL_WORD_WIDTH-1:0] o_control_word,
   output logic                          o_halted,
   output logic                          o_fault,
   output logic [COUNT_WIDTH-1:0]        o_instr_count
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_FAULT  = 2'd2
   } state_e;

   localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

   state_e                       state_q;
   logic [STEP_WIDTH-1:0]        step_q;
   logic [STEP_WIDTH-1:0]        step_d;
   logic [INSTRUCTION_WIDTH-1:0] instr_q;
   logic [FLAG_WIDTH-1:0]        flags_q;
   logic [COUNT_WIDTH-1:0]       count_q;
   logic [COUNT_WIDTH-1:0]       count_d;
   logic                         step_req;
   logic                         en;
   logic                         last_step;

   // Reset gates the enable so no control word escapes during the reset cycle.
   assign step_req  = i_single ? i_step_pulse : i_run;
   assign en        = !i_reset && (state_q == ST_RUN) && step_req;
   assign last_step = (step_q == LAST_STEP);
   assign step_d    = last_step ? '0 : step_q + STEP_WIDTH'(1);
   assign count_d   = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);

   assign o_control_word = en ? i_decoded_word : '0;
   assign o_instruction  = instr_q;
   assign o_step         = step_q;
   assign o_flags        = flags_q;
   assign o_instr_count  = count_q;
   assign o_halted       = (state_q == ST_HALTED);
`ifdef MICROCODE_SEQUENCER_WATCHDOG_EN
   assign o_fault        = (state_q == ST_FAULT);
`else
   assign o_fault        = 1'b0;
`endif

   // Sequencer state and datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_RUN;
         step_q  <= '0;
         instr_q <= '0;
         flags_q <= '0;
         count_q <= '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (en) begin
                  if (i_decoded_word[II_BIT]) instr_q <= i_bus;
                  if (i_decoded_word[EL_BIT]) flags_q <= i_alu_flags;
                  if (i_decoded_word[HLT_BIT]) begin
                     state_q <= ST_HALTED;
                     step_q  <= '0;
                  end else if (i_decoded_word[ADV_BIT]) begin
                     step_q  <= '0;
                     count_q <= count_d;
                  end else if (last_step) begin
`ifdef MICROCODE_SEQUENCER_WATCHDOG_EN
                     state_q <= ST_FAULT;
`else
                     step_q  <= step_d;
`endif
                  end else begin
                     step_q <= step_d;
                  end
               end
            end
            ST_HALTED: begin
               if (i_resume) begin
                  state_q <= ST_RUN;
                  step_q  <= '0;
               end
            end
            ST_FAULT: begin
               state_q <= ST_FAULT;
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 16, width of instruction register.
REQ-002 SHALL have parameter INSTRUCTION_STEPS, default 32, microsteps per instruction; STEP_WIDTH = $clog2(INSTRUCTION_STEPS).
REQ-003 SHALL have parameter CONTROL_WORD_WIDTH, default 32, control word width.
REQ-004 SHALL have parameter FLAG_WIDTH, default 3, number of ALU flags (bit0 zero, bit1 carry, bit2 odd).
REQ-005 SHALL have parameter COUNT_WIDTH, default 16, retired-instruction counter width.
REQ-006 SHALL have parameters ADV_BIT, HLT_BIT, II_BIT, EL_BIT, each a control-word bit index, defaults 0, 1, 2, 3.
REQ-007 SHALL have ports: i_clk input 1, system clock; i_reset input 1, synchronous active-high reset.
REQ-008 SHALL have ports: i_run input 1, free-run enable; i_single input 1, single-step mode; i_step_pulse input 1, one-cycle advance request; i_resume input 1, leave HALTED.
REQ-009 SHALL have ports: i_bus input INSTRUCTION_WIDTH, data bus; i_alu_flags input FLAG_WIDTH, live ALU flags; i_decoded_word input CONTROL_WORD_WIDTH, output of external combinational decoder.
REQ-010 SHALL have ports: o_instruction output INSTRUCTION_WIDTH, latched IR; o_step output STEP_WIDTH, current microstep; o_flags output FLAG_WIDTH, latched flags; o_control_word output CONTROL_WORD_WIDTH, gated control word; o_halted output 1; o_fault output 1; o_instr_count output COUNT_WIDTH.

Function
REQ-011 SHALL implement states RUN, HALTED, FAULT; o_halted = (state==HALTED), o_fault = (state==FAULT).
REQ-012 SHALL define enable en = (state==RUN) & (i_single ? i_step_pulse : i_run).
REQ-013 SHALL drive o_control_word = en ? i_decoded_word : 0, combinationally, zero latency.
REQ-014 On en: word[HLT_BIT] -> state HALTED, step <= 0; else word[ADV_BIT] -> step <= 0, o_instr_count += 1 saturating at all-ones; else step <= step+1.
REQ-015 HLT_BIT and ADV_BIT both set SHALL behave as HALT; counter not incremented.
REQ-016 On en with word[II_BIT], o_instruction <= i_bus next cycle; on en with word[EL_BIT], o_flags <= i_alu_flags next cycle; otherwise both hold.
REQ-017 Without en, step, IR, flags, counter and state SHALL hold.
REQ-018 HALTED: o_control_word = 0; i_resume high -> RUN next cycle with step 0; i_run/i_step_pulse ignored.
REQ-019 Step overflow (en, step == INSTRUCTION_STEPS-1, no ADV/HLT) SHALL be handled per REQ-024/REQ-025.
REQ-020 i_step_pulse held high multiple cycles in single mode SHALL advance once per cycle high; edge detection is caller's job.

Reset
REQ-021 i_reset sampled high SHALL, next edge, set state RUN, o_step 0, o_instruction 0, o_flags 0, o_instr_count 0, regardless of current state or step.
REQ-022 Reset SHALL take priority over en, i_resume and every control bit in the same cycle.
REQ-023 During reset cycle o_control_word SHALL equal 0.

Configuration
REQ-024 With MICROCODE_SEQUENCER_WATCHDOG_EN defined: step overflow SHALL enter FAULT, step held, o_control_word 0; only i_reset exits FAULT.
REQ-025 Without MICROCODE_SEQUENCER_WATCHDOG_EN: step overflow SHALL wrap step to 0, no state change, counter not incremented; FAULT unreachable, o_fault tied 0.

Verification
REQ-026 Reset, i_run=1, decoder returns ADV at step 2 -> steps 0,1,2,0; o_instr_count=1 after third edge.
REQ-027 Word with II_BIT at step 1, i_bus=16'h002a -> o_instruction=16'h002a next cycle; EL_BIT with flags 3'b101 -> o_flags=3'b101.
REQ-028 Word HLT|ADV at step 2 -> o_halted=1, o_step=0, count unchanged, o_control_word=0; i_resume pulse -> RUN, step 0.
REQ-029 i_single=1, i_run=1, three pulses over ten cycles -> step advances exactly 0->3, control word nonzero only in pulse cycles.
REQ-030 Decoder never asserts ADV, INSTRUCTION_STEPS=8 -> with macro o_fault=1 after 8 enabled cycles, held until reset; without macro step wraps 7->0.
REQ-031 i_reset asserted at step 5 with HLT word present -> next cycle all outputs at reset values, state RUN.
